// File: rtl/vpu_fp_max_reduce_pkg.sv
// Shared types and constants for the FP max-reduction issue stage.
//   OPERAND_WIDTH   : FP32 operand width used on every data path
//   max_red_state_t : FSM state encoding (StIdle, StRun, StFinish)
package vpu_fp_max_reduce_pkg;

  localparam int unsigned OPERAND_WIDTH = 32;

  typedef logic [1:0] max_red_state_t;

  localparam max_red_state_t StIdle   = 2'd0;
  localparam max_red_state_t StRun    = 2'd1;
  localparam max_red_state_t StFinish = 2'd2;

endpackage

// File: rtl/vpu_fp_max_reduce_if.sv
// Link between the reduction issue stage and the two-input FP max unit.
//   operand_0/operand_1 : operand pair, valid with start
//   start               : one-cycle issue strobe
//   result/done         : returned maximum, valid with done
// master = issue stage, slave = max unit.
interface vpu_fp_max_reduce_if;
  import vpu_fp_max_reduce_pkg::*;

  logic [OPERAND_WIDTH-1:0] operand_0;
  logic [OPERAND_WIDTH-1:0] operand_1;
  logic                     start;
  logic [OPERAND_WIDTH-1:0] result;
  logic                     done;

  modport master (
    output operand_0,
    output operand_1,
    output start,
    input  result,
    input  done
  );

  modport slave (
    input  operand_0,
    input  operand_1,
    input  start,
    output result,
    output done
  );

endinterface

// File: rtl/vpu_max_partial_buf.sv
// Partial-result FIFO for the max reduction.
//   push_i/push_data_i : write one entry
//   pop_cnt_i          : drop 0, 1 or 2 entries from the head
//   head0_o/head1_o    : first and second entries (head1 meaningful when count_o >= 2)
//   count_o            : current occupancy
// Depth must be a power of two so the pointers wrap naturally.
// Synchronous active-high reset clears pointers and count; storage is not reset.
module vpu_max_partial_buf
  import vpu_fp_max_reduce_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = OPERAND_WIDTH,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic [1:0]       pop_cnt_i,
  output logic [Width-1:0] head0_o,
  output logic [Width-1:0] head1_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt_i);
    wr_ptr_d = wr_ptr_q + PtrW'(push_i);
    count_d  = count_q + CntW'(push_i) - CntW'(pop_cnt_i);
  end

  assign head0_o = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + PtrW'(1)];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/vpu_fp_max_reduce.sv
// Issue stage that reduces a streamed FP32 vector to its maximum using an external
// two-input max unit. Elements land in a 2-entry hold register; pairs of holds or pairs of
// returned partials are issued to the unit, keeping at most MAX_OUTSTANDING ops in flight.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   elem_i/elem_valid_i/elem_last_i/elem_ready_o : element stream in
//   unit_io             : max unit link (operands/start out, result/done in)
//   result_o/done_o     : final maximum with one-cycle done pulse
//   busy_o              : vector in progress
//   issue_cnt_o         : issues for the current vector (only with VPU_MAX_REDUCE_STAT_EN)
// Build option: define VPU_MAX_REDUCE_STAT_EN to add the issue counter port.
module vpu_fp_max_reduce
  import vpu_fp_max_reduce_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PBUF_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPERAND_WIDTH-1:0] elem_i,
  input  logic                     elem_valid_i,
  input  logic                     elem_last_i,
  output logic                     elem_ready_o,
  vpu_fp_max_reduce_if.master      unit_io,
  output logic [OPERAND_WIDTH-1:0] result_o,
  output logic                     done_o,
  output logic                     busy_o
`ifdef VPU_MAX_REDUCE_STAT_EN
  ,
  output logic [15:0]              issue_cnt_o
`endif
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CntW = $clog2(PBUF_DEPTH + 1);

  max_red_state_t           state_q, state_d;
  logic [OPERAND_WIDTH-1:0] hold_q [2];
  logic [OPERAND_WIDTH-1:0] hold_d [2];
  logic [1:0]               hold_cnt_q, hold_cnt_d;
  logic [OutW-1:0]          outstanding_q, outstanding_d;
  logic                     last_seen_q, last_seen_d;
  logic [OPERAND_WIDTH-1:0] op0_q, op0_d, op1_q, op1_d;
  logic                     start_q, start_d;
  logic [OPERAND_WIDTH-1:0] result_q, result_d;
  logic                     done_q, done_d;

  logic [OPERAND_WIDTH-1:0] pbuf_head0, pbuf_head1;
  logic [CntW-1:0]          pbuf_cnt;
  logic [1:0]               pbuf_pop;
  logic                     unit_ret;

  logic elem_accept, run, slot_free, term;
  logic rule_pp, rule_hh, rule_hp;
  logic issue_pp, issue_hh, issue_hp, issue;

  assign elem_ready_o = (state_q != StFinish) && (hold_cnt_q < 2'd2) && !last_seen_q;
  assign elem_accept  = elem_valid_i && elem_ready_o;
  assign run          = (state_q == StRun);
  assign slot_free    = (outstanding_q < OutW'(MAX_OUTSTANDING));

  // Results arriving with nothing in flight are leftovers from before a reset.
  assign unit_ret = unit_io.done && (outstanding_q != '0);

  assign rule_pp = (pbuf_cnt >= CntW'(2));
  assign rule_hh = (hold_cnt_q == 2'd2);
  assign rule_hp = last_seen_q && (hold_cnt_q == 2'd1) && (pbuf_cnt == CntW'(1));

  assign issue_pp = run && slot_free && rule_pp;
  assign issue_hh = run && slot_free && !rule_pp && rule_hh;
  assign issue_hp = run && slot_free && !rule_pp && !rule_hh && rule_hp;
  assign issue    = issue_pp || issue_hh || issue_hp;

  // Exactly one value left and nothing in flight: it is the maximum.
  assign term = run && last_seen_q && (outstanding_q == '0) &&
                (((pbuf_cnt == CntW'(1)) && (hold_cnt_q == 2'd0)) ||
                 ((hold_cnt_q == 2'd1) && (pbuf_cnt == CntW'(0))));

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_cnt_d    = hold_cnt_q;
    last_seen_d   = last_seen_q;
    outstanding_d = outstanding_q + OutW'(issue) - OutW'(unit_ret);
    op0_d         = '0;
    op1_d         = '0;
    start_d       = issue;
    result_d      = result_q;
    done_d        = 1'b0;
    pbuf_pop      = 2'd0;

    if (issue_pp) begin
      op0_d    = pbuf_head0;
      op1_d    = pbuf_head1;
      pbuf_pop = 2'd2;
    end else if (issue_hh) begin
      op0_d      = hold_q[0];
      op1_d      = hold_q[1];
      hold_cnt_d = 2'd0;
    end else if (issue_hp) begin
      op0_d      = hold_q[0];
      op1_d      = pbuf_head0;
      pbuf_pop   = 2'd1;
      hold_cnt_d = 2'd0;
    end

    // No issue can drain the holds while one is accepted (ready needs hold_cnt < 2).
    if (elem_accept) begin
      hold_d[hold_cnt_q[0]] = elem_i;
      hold_cnt_d            = hold_cnt_q + 2'd1;
      if (elem_last_i) begin
        last_seen_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (elem_accept) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (term) begin
          state_d = StFinish;
          done_d  = 1'b1;
          if (hold_cnt_q == 2'd1) begin
            result_d   = hold_q[0];
            hold_cnt_d = 2'd0;
          end else begin
            result_d = pbuf_head0;
            pbuf_pop = 2'd1;
          end
        end
      end
      StFinish: begin
        state_d     = StIdle;
        last_seen_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      hold_q[0]     <= '0;
      hold_q[1]     <= '0;
      hold_cnt_q    <= '0;
      outstanding_q <= '0;
      last_seen_q   <= 1'b0;
      op0_q         <= '0;
      op1_q         <= '0;
      start_q       <= 1'b0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_cnt_q    <= hold_cnt_d;
      outstanding_q <= outstanding_d;
      last_seen_q   <= last_seen_d;
      op0_q         <= op0_d;
      op1_q         <= op1_d;
      start_q       <= start_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  vpu_max_partial_buf #(
    .Depth (PBUF_DEPTH),
    .Width (OPERAND_WIDTH)
  ) u_pbuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (unit_ret),
    .push_data_i (unit_io.result),
    .pop_cnt_i   (pbuf_pop),
    .head0_o     (pbuf_head0),
    .head1_o     (pbuf_head1),
    .count_o     (pbuf_cnt)
  );

  assign unit_io.operand_0 = op0_q;
  assign unit_io.operand_1 = op1_q;
  assign unit_io.start     = start_q;
  assign result_o          = result_q;
  assign done_o            = done_q;
  assign busy_o            = (state_q != StIdle);

`ifdef VPU_MAX_REDUCE_STAT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if ((state_q == StIdle) && elem_accept) begin
      issue_cnt_d = '0;
    end else if (issue) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_cnt_o = issue_cnt_q;
`endif

endmodule

// File: tb/tb_vpu_fp_max_reduce.sv
module tb_vpu_fp_max_reduce;

  localparam int Budget = 500;

  logic        clk;
  logic        rst;
  logic [31:0] elem;
  logic        elem_valid;
  logic        elem_last;
  logic        elem_ready;
  logic [31:0] result;
  logic        done;
  logic        busy;
`ifdef VPU_MAX_REDUCE_STAT_EN
  logic [15:0] issue_cnt;
`endif

  vpu_fp_max_reduce_if uif ();

  vpu_fp_max_reduce #(
    .MAX_OUTSTANDING (2),
    .PBUF_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .elem_i       (elem),
    .elem_valid_i (elem_valid),
    .elem_last_i  (elem_last),
    .elem_ready_o (elem_ready),
    .unit_io      (uif),
    .result_o     (result),
    .done_o       (done),
    .busy_o       (busy)
`ifdef VPU_MAX_REDUCE_STAT_EN
    ,
    .issue_cnt_o  (issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FP32 max for non-NaN values via a monotonic integer key.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    return (ka >= kb) ? a : b;
  endfunction

  // Max unit model: fixed latency, results returned in order.
  typedef struct {
    logic [31:0] res;
    int          due;
  } unit_op_t;

  unit_op_t uq[$];
  int       unit_lat = 3;
  int       peak_outstanding = 0;

  always @(negedge clk) begin
    if (uif.start) begin
      uq.push_back('{res: fmax(uif.operand_0, uif.operand_1), due: ncyc + unit_lat});
      if (uq.size() > peak_outstanding) peak_outstanding = uq.size();
    end
    if (uq.size() > 0 && uq[0].due <= ncyc) begin
      uif.done   = 1'b1;
      uif.result = uq[0].res;
      void'(uq.pop_front());
    end else begin
      uif.done   = 1'b0;
      uif.result = '0;
    end
  end

  // Scoreboard
  typedef struct {
    string       name;
    logic [31:0] res;
    int          issues;
    int          lat;
  } sb_entry_t;

  sb_entry_t exp_q[$];
  int        vec_starts = 0;
  int        last_acc_cyc = 0;

  always @(negedge clk) begin
    sb_entry_t e;
    if (rst) begin
      vec_starts = 0;
    end else begin
      if (uif.start) vec_starts++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_issues"}, 32'(vec_starts), 32'(e.issues));
          if (e.lat >= 0) check({e.name, "_done_latency"}, 32'(ncyc - last_acc_cyc), 32'(e.lat));
        end
        vec_starts = 0;
      end
    end
  end

  logic [31:0] vec [16];
  bit          stall_seen;

  // Called at a negedge; returns at a negedge with valid dropped.
  task automatic send_vec(input string name, input int n, input int lat, input int stop_starts);
    sb_entry_t   e;
    logic [31:0] m;
    int          budget;
    m = vec[0];
    for (int i = 1; i < n; i++) m = fmax(m, vec[i]);
    if (stop_starts == 0) begin
      e.name = name; e.res = m; e.issues = n - 1; e.lat = lat;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (stop_starts != 0 && vec_starts >= stop_starts) break;
      elem_valid = 1'b1;
      elem       = vec[i];
      elem_last  = (i == n - 1);
      budget     = 0;
      while (!elem_ready && budget < Budget) begin
        if (i < n - 1) stall_seen = 1'b1;
        @(negedge clk);
        budget++;
      end
      if (budget >= Budget) begin
        check({name, "_ready_timeout"}, 32'd0, 32'd1);
        break;
      end
      last_acc_cyc = ncyc;
      @(negedge clk);
    end
    elem_valid = 1'b0;
    elem_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) check({name, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int budget;
    rst        = 1'b1;
    elem       = '0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_result", result, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_start", {31'd0, uif.start}, 32'd0);
    check("rst_op0", uif.operand_0, 32'h0);
    check("rst_op1", uif.operand_1, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, elem_ready}, 32'd1);

    // Single element: no issue, done two cycles after acceptance.
    vec[0] = 32'h4040_0000;
    send_vec("one", 1, 2, 0);
    wait_idle("one");

    // Four elements back to back.
    vec[0] = 32'h3F80_0000; vec[1] = 32'h40A0_0000;
    vec[2] = 32'hC000_0000; vec[3] = 32'h4040_0000;
    send_vec("four", 4, -1, 0);
    wait_idle("four");
`ifdef VPU_MAX_REDUCE_STAT_EN
    check("stat_after_four", {16'd0, issue_cnt}, 32'd3);
    vec[0] = 32'h4040_0000;
    send_vec("stat_one", 1, -1, 0);
    wait_idle("stat_one");
    check("stat_cleared", {16'd0, issue_cnt}, 32'd0);
`endif

    // Five elements: odd leftover pairs a hold with a partial.
    vec[0] = 32'h4000_0000; vec[1] = 32'h4110_0000; vec[2] = 32'h4080_0000;
    vec[3] = 32'h40E0_0000; vec[4] = 32'h3F80_0000;
    send_vec("five", 5, -1, 0);
    wait_idle("five");

    // Sixteen elements with a slow unit.
    for (int i = 0; i < 16; i++) begin
      vec[i] = {(i % 3 == 0), 8'd125 + 8'(i % 7), 23'((i * 40503) & 32'h7F_FFFF)};
    end
    unit_lat   = 12;
    stall_seen = 1'b0;
    send_vec("stall16", 16, -1, 0);
    wait_idle("stall16");
    check("stall16_ready_low", {31'd0, stall_seen}, 32'd1);
    unit_lat = 3;

    // Reset after two issues of an eight-element vector.
    for (int i = 0; i < 8; i++) vec[i] = 32'h42C8_0000 + 32'(i << 16);
    send_vec("abort8", 8, -1, 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_result", result, 32'h0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_start", {31'd0, uif.start}, 32'd0);
    check("abort_op0", uif.operand_0, 32'h0);
    check("abort_op1", uif.operand_1, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    budget = 0;
    while (uq.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    check("abort_stale_busy", {31'd0, busy}, 32'd0);

    vec[0] = 32'h3F80_0000; vec[1] = 32'h4000_0000;
    send_vec("two", 2, -1, 0);
    wait_idle("two");

    check("peak_outstanding", 32'(peak_outstanding), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
